uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Receive buffer that sits directly downstream of the UART receiver deserializer and upstream of the host-side read port.
- Accepts one received character per push strobe, together with its 3-bit receive error code.
- Presents the oldest character on a registered output when Pop_Data is strobed.
- Generates the FIFO_Empty, Data_Rdy, FIFO_Full (high-water) and FIFO_Overflow status signals; the RTS flow-control output is derived from FIFO_Full.

Parameters:
- DATA_BITS, 8, width of one received character.
- FIFO_WIDTH, 8, address bits; depth FIFO_ENTRIES = 2**FIFO_WIDTH (localparam).
- HIGH_WATER, FIFO_ENTRIES/2 + 1, occupancy at or above which FIFO_Full asserts.

Ports:
- Clk  in  1  receiver clock; all logic on rising edge
- Rst  in  1  asynchronous, active-low reset
- Rx_Push  in  1  one-cycle strobe from receiver: character complete
- Rx_Data_In  in  DATA_BITS  received character, valid with Rx_Push
- Rx_Err_In  in  3  receive error code {frame, parity, break}, valid with Rx_Push
- Pop_Data  in  1  one-cycle strobe: load next entry onto Data_Out
- Data_Out  out  DATA_BITS  registered output character
- Rx_Error  out  3  error code of the entry currently on Data_Out
- Data_Rdy  out  1  FIFO holds at least one unread entry
- FIFO_Empty  out  1  occupancy == 0
- FIFO_Full  out  1  occupancy >= HIGH_WATER
- FIFO_Overflow  out  1  sticky: a push was dropped
- RTS  out  1  ready-to-send to far end, = !FIFO_Full
- Count  out  FIFO_WIDTH+1  current occupancy, 0..FIFO_ENTRIES

Behaviour:
- Reset (Rst=0, asynchronous):
  - Pointers and Count = 0.
  - Data_Out = 0, Rx_Error = 0, FIFO_Overflow = 0, FIFO_Full = 0.
  - FIFO_Empty = 1, Data_Rdy = 0, RTS = 1.
  - Memory contents are not reset.
- Reset mid-operation discards all entries immediately. The first push after release lands at address 0.
- Push, when Rx_Push=1 and Count < FIFO_ENTRIES:
  - Write {Rx_Err_In, Rx_Data_In} at wr_ptr.
  - wr_ptr increments, wrapping from FIFO_ENTRIES-1 to 0.
  - Count increments.
- Pop, when Pop_Data=1 and Count > 0:
  - Data_Out/Rx_Error <= mem[rd_ptr] on that edge. Data is valid in the cycle after the strobe, i.e. 1-cycle latency.
  - rd_ptr increments with wrap; Count decrements.
- Pop when empty:
  - Ignored; Data_Out and Rx_Error hold; no pointer change.
  - A push in the same cycle is not bypassed: a push and pop together on an empty FIFO yields Count=1, Data_Out unchanged.
- Push and pop in the same cycle with 0 < Count < FIFO_ENTRIES: both occur, Count unchanged.
- Push when Count == FIFO_ENTRIES:
  - Without a pop in the same cycle: the character is dropped, memory is unchanged, and FIFO_Overflow sets.
  - With a pop in the same cycle: both occur, Count stays at FIFO_ENTRIES, no overflow.
- FIFO_Overflow is sticky. It clears on the first successful pop after it was set, or on reset.
- Status outputs are combinational from registered Count only; no output depends combinationally on any input.
- Data_Rdy = !FIFO_Empty.
- Count is kept as a separate register; it is not derived from pointer difference. Pointers are FIFO_WIDTH bits and wrap naturally.

Optional Feature:
- Macro: UART_RX_FIFO_ERR_TAG_EN.
- Defined: memory word is DATA_BITS+3 bits; Rx_Error tracks each popped entry as described above.
- Undefined: memory word is DATA_BITS bits; Rx_Err_In is ignored and Rx_Error is tied to 3'b000.

Decomposition:
- Package uart_pkg holds:
  - rx_err_t, a packed 3-bit struct {frame, parity, break}.
  - The RX_ERR_BREAK/PARITY/FRAME bit-index constants.
  - The default DATA_BITS and FIFO_WIDTH localparams, shared with the receiver and BIST.
- One sub-module, uart_fifo_mem: a simple dual-port synchronous RAM with one write port and one registered read port, parameterised by word width and address width. The pointer, count and flag logic stays in uart_rx_fifo.

Test Plan:
- Reset then idle → FIFO_Empty=1, Data_Rdy=0, RTS=1, Count=0, Data_Out=0.
- Push 0x00..0x0F, then 16 pops → Data_Out equals 0x00..0x0F in order, each valid one cycle after its Pop_Data; FIFO_Empty=1 at end.
- With FIFO_WIDTH=4, push 9 entries → FIFO_Full and !RTS assert after the 9th push; pop 1 → FIFO_Full=0, RTS=1.
- With FIFO_WIDTH=4, push 17 → 17th is dropped, FIFO_Overflow=1, Count=16; next pop returns the first entry and clears FIFO_Overflow. Push+pop together at Count=16 → no overflow.
- Push 0xAA with Rx_Err_In=3'b010, then pop → Data_Out=0xAA, Rx_Error=3'b010 with ERR_TAG_EN defined; Rx_Error=3'b000 without it.
- Push 5 entries, assert Rst=0 mid-stream between clock edges → flags return to reset values immediately; after release, push 0x55 then pop → 0x55.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive error tag layout and default widths.
// Used by the receiver, the receive FIFO and BIST.
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_FIFO_WIDTH = 8;

  localparam int RX_ERR_BREAK  = 0;
  localparam int RX_ERR_PARITY = 1;
  localparam int RX_ERR_FRAME  = 2;

  typedef struct packed {
    logic frame;
    logic parity;
    logic brk;
  } rx_err_t;

  function automatic rx_err_t to_rx_err(
    input logic [2:0] i_v
  );
    return rx_err_t'(i_v);
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Simple dual-port RAM: one write port, one registered read port.
// Array contents are not reset; only the read register is.
module uart_fifo_mem #(
  parameter int WORD_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [2**ADDR_W];
  logic [WORD_W-1:0] r_rdata;

  // Write port.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Read register holds its value between reads.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer with high-water flow control and sticky overflow.
// Define UART_RX_FIFO_ERR_TAG_EN to store the 3-bit error code per entry.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int FIFO_WIDTH = UART_FIFO_WIDTH,
  parameter int HIGH_WATER = (2**FIFO_WIDTH)/2 + 1
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Rx_Push,
  input  logic [DATA_BITS-1:0]  Rx_Data_In,
  input  logic [2:0]            Rx_Err_In,
  input  logic                  Pop_Data,
  output logic [DATA_BITS-1:0]  Data_Out,
  output logic [2:0]            Rx_Error,
  output logic                  Data_Rdy,
  output logic                  FIFO_Empty,
  output logic                  FIFO_Full,
  output logic                  FIFO_Overflow,
  output logic                  RTS,
  output logic [FIFO_WIDTH:0]   Count
);

  localparam int FIFO_ENTRIES = 2**FIFO_WIDTH;
  localparam logic [FIFO_WIDTH:0] C_ENTRIES =
    (FIFO_WIDTH+1)'(FIFO_ENTRIES);
  localparam logic [FIFO_WIDTH:0] C_HW =
    (FIFO_WIDTH+1)'(HIGH_WATER);

`ifdef UART_RX_FIFO_ERR_TAG_EN
  localparam int WORD_W = DATA_BITS + 3;
`else
  localparam int WORD_W = DATA_BITS;
`endif

  logic [FIFO_WIDTH-1:0] r_wr_ptr;
  logic [FIFO_WIDTH-1:0] r_rd_ptr;
  logic [FIFO_WIDTH:0]   r_count;
  logic                  r_ovf;

  logic              w_full_all;
  logic              w_do_pop;
  logic              w_do_push;
  logic              w_drop;
  logic [WORD_W-1:0] w_wdata;
  logic [WORD_W-1:0] w_rdata;

  assign w_full_all = (r_count == C_ENTRIES);
  assign w_do_pop   = Pop_Data && (r_count != '0);
  assign w_do_push  = Rx_Push && (!w_full_all || w_do_pop);
  assign w_drop     = Rx_Push && w_full_all && !w_do_pop;

`ifdef UART_RX_FIFO_ERR_TAG_EN
  rx_err_t w_err_in;
  rx_err_t w_err_out;
  assign w_err_in  = to_rx_err(Rx_Err_In);
  assign w_wdata   = {w_err_in, Rx_Data_In};
  assign w_err_out = to_rx_err(w_rdata[DATA_BITS +: 3]);
  assign Rx_Error  = w_err_out;
`else
  logic w_unused_err;
  assign w_unused_err = ^Rx_Err_In;
  assign w_wdata      = Rx_Data_In;
  assign Rx_Error     = 3'b000;
`endif

  uart_fifo_mem #(
    .WORD_W (WORD_W),
    .ADDR_W (FIFO_WIDTH)
  ) u_mem (
    .i_clk   (Clk),
    .i_rst_n (Rst),
    .i_we    (w_do_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wdata),
    .i_re    (w_do_pop),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  // Pointers wrap naturally at FIFO_WIDTH bits.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Occupancy is its own register, not a pointer difference.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_count <= '0;
    end else begin
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky drop flag, cleared by the next successful pop.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)          r_ovf <= 1'b0;
    else if (w_drop)   r_ovf <= 1'b1;
    else if (w_do_pop) r_ovf <= 1'b0;
  end

  assign Data_Out      = w_rdata[DATA_BITS-1:0];
  assign Count         = r_count;
  assign FIFO_Empty    = (r_count == '0);
  assign Data_Rdy      = !FIFO_Empty;
  assign FIFO_Full     = (r_count >= C_HW);
  assign RTS           = !FIFO_Full;
  assign FIFO_Overflow = r_ovf;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo at FIFO_WIDTH=4 against a queue model.
// Honors UART_RX_FIFO_ERR_TAG_EN for the expected Rx_Error.
module tb_uart_rx_fifo;

  localparam int DW = 8;
  localparam int FW = 4;
  localparam int N  = 16;
  localparam int HW = 9;
`ifdef UART_RX_FIFO_ERR_TAG_EN
  localparam bit TAG = 1'b1;
`else
  localparam bit TAG = 1'b0;
`endif

  logic          Clk = 1'b0;
  logic          Rst;
  logic          Rx_Push;
  logic [DW-1:0] Rx_Data_In;
  logic [2:0]    Rx_Err_In;
  logic          Pop_Data;
  logic [DW-1:0] Data_Out;
  logic [2:0]    Rx_Error;
  logic          Data_Rdy;
  logic          FIFO_Empty;
  logic          FIFO_Full;
  logic          FIFO_Overflow;
  logic          RTS;
  logic [FW:0]   Count;

  uart_rx_fifo #(
    .DATA_BITS  (DW),
    .FIFO_WIDTH (FW)
  ) dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .Rx_Push       (Rx_Push),
    .Rx_Data_In    (Rx_Data_In),
    .Rx_Err_In     (Rx_Err_In),
    .Pop_Data      (Pop_Data),
    .Data_Out      (Data_Out),
    .Rx_Error      (Rx_Error),
    .Data_Rdy      (Data_Rdy),
    .FIFO_Empty    (FIFO_Empty),
    .FIFO_Full     (FIFO_Full),
    .FIFO_Overflow (FIFO_Overflow),
    .RTS           (RTS),
    .Count         (Count)
  );

  always #5 Clk = ~Clk;

  logic [10:0]   q[$];
  logic [DW-1:0] m_dout;
  logic [2:0]    m_err;
  logic          m_ovf;
  int n_pass = 0;
  int n_total = 0;

  wire [20:0] obs = {Count, FIFO_Full, FIFO_Empty, Data_Rdy,
                     RTS, FIFO_Overflow, Rx_Error, Data_Out};

  function automatic logic [20:0] expv();
    int s;
    s = q.size();
    return {5'(s), s >= HW, s == 0, s != 0, s < HW,
            m_ovf, m_err, m_dout};
  endfunction

  task automatic model_reset();
    q.delete();
    m_dout = '0;
    m_err  = '0;
    m_ovf  = 1'b0;
  endtask

  task automatic step(input logic push, input logic [7:0] d,
                      input logic [2:0] e, input logic pop);
    logic [10:0] ent;
    bit do_pop;
    bit full;
    Rx_Push = push;
    Rx_Data_In = d;
    Rx_Err_In = e;
    Pop_Data = pop;
    @(posedge Clk);
    full   = (q.size() == N);
    do_pop = pop && (q.size() > 0);
    if (do_pop) begin
      ent    = q.pop_front();
      m_dout = ent[7:0];
      m_err  = TAG ? ent[10:8] : 3'b000;
      m_ovf  = 1'b0;
    end
    if (push) begin
      if (!full || do_pop) q.push_back({e, d});
      else m_ovf = 1'b1;
    end
    #1;
    Rx_Push = 1'b0;
    Pop_Data = 1'b0;
  endtask

  task automatic drain();
    while (q.size() > 0) step(0, 8'h00, 3'b000, 1);
  endtask

  task automatic test_reset();
    Rst = 1'b0;
    Rx_Push = 1'b0;
    Pop_Data = 1'b0;
    Rx_Data_In = '0;
    Rx_Err_In = '0;
    model_reset();
    #12;
    n_total++;
    if (obs !== expv())
      $display("FAIL reset obs=%h exp=%h", obs, expv());
    else n_pass++;
    Rst = 1'b1;
    repeat (3) step(0, 8'h00, 3'b000, 0);
    n_total++;
    if (obs !== expv())
      $display("FAIL idle obs=%h exp=%h", obs, expv());
    else n_pass++;
  endtask

  task automatic test_order();
    for (int i = 0; i < 16; i++)
      step(1, 8'(i), 3'($urandom_range(7)), 0);
    n_total++;
    if (obs !== expv())
      $display("FAIL order_fill obs=%h exp=%h", obs, expv());
    else n_pass++;
    for (int i = 0; i < 16; i++) begin
      step(0, 8'h00, 3'b000, 1);
      n_total++;
      if (Data_Out !== 8'(i) || obs !== expv())
        $display("FAIL order_pop%0d got=%h want=%h obs=%h exp=%h",
                 i, Data_Out, 8'(i), obs, expv());
      else n_pass++;
    end
    n_total++;
    if (FIFO_Empty !== 1'b1)
      $display("FAIL order_empty got=%b want=1", FIFO_Empty);
    else n_pass++;
  endtask

  task automatic test_high_water();
    for (int i = 0; i < 9; i++) begin
      step(1, 8'($urandom), 3'b000, 0);
      if (i >= 7) begin
        n_total++;
        if (FIFO_Full !== (i == 8) || RTS !== (i != 8))
          $display("FAIL hw_push%0d full=%b rts=%b want_full=%b",
                   i, FIFO_Full, RTS, i == 8);
        else n_pass++;
      end
    end
    step(0, 8'h00, 3'b000, 1);
    n_total++;
    if (FIFO_Full !== 1'b0 || RTS !== 1'b1 || obs !== expv())
      $display("FAIL hw_pop full=%b rts=%b obs=%h exp=%h",
               FIFO_Full, RTS, obs, expv());
    else n_pass++;
  endtask

  task automatic test_overflow();
    logic [7:0] first;
    drain();
    for (int i = 0; i < 17; i++)
      step(1, 8'h30 + 8'(i), 3'b001, 0);
    first = 8'h30;
    n_total++;
    if (FIFO_Overflow !== 1'b1 || Count !== 5'd16 ||
        obs !== expv())
      $display("FAIL ovf_set ovf=%b cnt=%0d obs=%h exp=%h",
               FIFO_Overflow, Count, obs, expv());
    else n_pass++;
    step(0, 8'h00, 3'b000, 1);
    n_total++;
    if (Data_Out !== first || FIFO_Overflow !== 1'b0 ||
        obs !== expv())
      $display("FAIL ovf_clear dout=%h ovf=%b obs=%h exp=%h",
               Data_Out, FIFO_Overflow, obs, expv());
    else n_pass++;
    step(1, 8'h99, 3'b000, 0);
    step(1, 8'h9A, 3'b000, 1);
    n_total++;
    if (FIFO_Overflow !== 1'b0 || Count !== 5'd16 ||
        obs !== expv())
      $display("FAIL ovf_pushpop ovf=%b cnt=%0d obs=%h exp=%h",
               FIFO_Overflow, Count, obs, expv());
    else n_pass++;
    drain();
    step(1, 8'h77, 3'b000, 1);
    n_total++;
    if (Count !== 5'd1 || obs !== expv())
      $display("FAIL empty_pushpop cnt=%0d obs=%h exp=%h",
               Count, obs, expv());
    else n_pass++;
    drain();
  endtask

  task automatic test_err_tag();
    logic [2:0] want;
    want = TAG ? 3'b010 : 3'b000;
    step(1, 8'hAA, 3'b010, 0);
    step(0, 8'h00, 3'b000, 1);
    n_total++;
    if (Data_Out !== 8'hAA || Rx_Error !== want)
      $display("FAIL err_tag dout=%h err=%b want=aa/%b",
               Data_Out, Rx_Error, want);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 5; i++)
      step(1, 8'($urandom), 3'($urandom_range(7)), 0);
    #2;
    Rst = 1'b0;
    model_reset();
    #1;
    n_total++;
    if (obs !== expv())
      $display("FAIL mid_reset obs=%h exp=%h", obs, expv());
    else n_pass++;
    Rst = 1'b1;
    step(1, 8'h55, 3'b000, 0);
    step(0, 8'h00, 3'b000, 1);
    n_total++;
    if (Data_Out !== 8'h55 || obs !== expv())
      $display("FAIL post_reset dout=%h obs=%h exp=%h",
               Data_Out, obs, expv());
    else n_pass++;
  endtask

  task automatic test_random();
    int bad;
    int pp;
    int pq;
    bad = 0;
    for (int i = 0; i < 600; i++) begin
      pp = ((i / 100) % 2 == 0) ? 75 : 30;
      pq = 100 - pp;
      step($urandom_range(99) < pp, 8'($urandom),
           3'($urandom_range(7)), $urandom_range(99) < pq);
      n_total++;
      if (obs !== expv()) begin
        if (bad < 10)
          $display("FAIL random%0d obs=%h exp=%h",
                   i, obs, expv());
        bad++;
      end else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_order();
    test_high_water();
    test_overflow();
    test_err_tag();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
